// File: rtl/sga_pkg.sv
// Shared definitions for the Snake Game Arcade datapath: direction codes,
// engine FSM state encodings and a direction helper.
package sga_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SCAN   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opposite direction: the codes are arranged so inverting both bits reverses.
  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return d ^ 2'b11;
  endfunction

endpackage

// File: rtl/sga_body_ram.sv
// Snake body store: circular buffer of {x,y} cells addressed relative to the head
// pointer (index 0 = head). One synchronous push port, two combinational read ports.
module sga_body_ram
  import sga_pkg::*;
#(
  parameter int X_BITS  = 2,
  parameter int Y_BITS  = 2,
  parameter int LB      = 4,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic              clock,
  input  logic              restart,
  input  logic              clear,
  input  logic              push,
  input  logic [X_BITS-1:0] wr_x,
  input  logic [Y_BITS-1:0] wr_y,
  input  logic [LB-1:0]     scan_idx,
  output logic [X_BITS-1:0] scan_x,
  output logic [Y_BITS-1:0] scan_y,
  input  logic [LB-1:0]     rd_idx,
  output logic [X_BITS-1:0] rd_x,
  output logic [Y_BITS-1:0] rd_y
);

  localparam int DEPTH = 2 ** LB;
  localparam int W     = X_BITS + Y_BITS;
  localparam logic [W-1:0]  START_XY = {X_BITS'(START_X), Y_BITS'(START_Y)};
  localparam logic [LB-1:0] PTR_ONE  = LB'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [LB-1:0] ptr;
  logic [LB-1:0] ptr_next;
  logic [LB-1:0] scan_addr;
  logic [LB-1:0] rd_addr;

  assign ptr_next  = ptr + PTR_ONE;
  assign scan_addr = ptr - scan_idx;
  assign rd_addr   = ptr - rd_idx;

  // Reset/clear park the single-segment body at the start cell in slot 0.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= START_XY;
      end
    end else if (clear) begin
      ptr    <= '0;
      mem[0] <= START_XY;
    end else if (push) begin
      ptr           <= ptr_next;
      mem[ptr_next] <= {wr_x, wr_y};
    end
  end

  assign {scan_x, scan_y} = mem[scan_addr];
  assign {rd_x, rd_y}     = mem[rd_addr];

endmodule

// File: rtl/sga_snake_engine.sv
// Snake body engine: per-step next-head, wall/self collision scan, apple growth and win.
// Build option SGA_WRAP_EN: coordinates wrap at the grid edge and wall_hit never rises.
module sga_snake_engine
  import sga_pkg::*;
#(
  parameter int X_BITS  = 2,
  parameter int Y_BITS  = 2,
  parameter int MAX_LEN = 16,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic                       clock,
  input  logic                       restart,
  input  logic                       init,
  input  logic                       step_valid,
  output logic                       step_ready,
  input  logic [1:0]                 dir_in,
  input  logic [X_BITS-1:0]          apple_x,
  input  logic [Y_BITS-1:0]          apple_y,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [X_BITS-1:0]          rd_x,
  output logic [Y_BITS-1:0]          rd_y,
  output logic [X_BITS-1:0]          head_x,
  output logic [Y_BITS-1:0]          head_y,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic [1:0]                 cur_dir,
  output logic                       done,
  output logic                       ate,
  output logic                       wall_hit,
  output logic                       self_hit,
  output logic                       won
);

  localparam int LB = $clog2(MAX_LEN);
  localparam logic [LB:0]     LEN_ONE     = (LB+1)'(1);
  localparam logic [LB:0]     LEN_PRE_WIN = (LB+1)'(MAX_LEN - 1);
  localparam logic [LB-1:0]   IDX_ONE     = LB'(1);
  localparam logic [X_BITS:0] X_ONE       = (X_BITS+1)'(1);
  localparam logic [Y_BITS:0] Y_ONE       = (Y_BITS+1)'(1);

  state_t            state;
  logic [1:0]        step_dir;
  logic [X_BITS-1:0] nxt_x;
  logic [Y_BITS-1:0] nxt_y;
  logic              eat_pend;
  logic              wall_pend;
  logic [LB-1:0]     idx;

  logic [X_BITS:0]   nx_ext;
  logic [Y_BITS:0]   ny_ext;
  logic              wall_now;
  logic [1:0]        eff_dir;
  logic [X_BITS-1:0] scan_x;
  logic [Y_BITS-1:0] scan_y;
  logic              scan_tail;
  logic              scan_match;
  logic              self_match;
  logic              push;

  assign push = (state == ST_COMMIT) && !init;

  sga_body_ram #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS),
    .LB     (LB),
    .START_X(START_X),
    .START_Y(START_Y)
  ) u_body (
    .clock   (clock),
    .restart (restart),
    .clear   (init),
    .push    (push),
    .wr_x    (nxt_x),
    .wr_y    (nxt_y),
    .scan_idx(idx),
    .scan_x  (scan_x),
    .scan_y  (scan_y),
    .rd_idx  (rd_idx),
    .rd_x    (rd_x),
    .rd_y    (rd_y)
  );

  // One extra bit on each axis exposes both underflow and overflow as the MSB.
  always_comb begin
    nx_ext = {1'b0, head_x};
    ny_ext = {1'b0, head_y};
    case (step_dir)
      DIR_RIGHT: nx_ext = {1'b0, head_x} + X_ONE;
      DIR_DOWN:  ny_ext = {1'b0, head_y} + Y_ONE;
      DIR_UP:    ny_ext = {1'b0, head_y} - Y_ONE;
      DIR_LEFT:  nx_ext = {1'b0, head_x} - X_ONE;
      default:   nx_ext = {1'b0, head_x};
    endcase
  end

`ifdef SGA_WRAP_EN
  assign wall_now = 1'b0;
`else
  assign wall_now = nx_ext[X_BITS] | ny_ext[Y_BITS];
`endif

  assign eff_dir = ((length != LEN_ONE) && (dir_in == dir_reverse(cur_dir))) ? cur_dir : dir_in;

  // The tail cell is vacated by a non-eating move, so it only collides when growing.
  assign scan_tail  = ({1'b0, idx} == (length - LEN_ONE));
  assign scan_match = (scan_x == nxt_x) && (scan_y == nxt_y);
  assign self_match = scan_match && (!scan_tail || eat_pend);

  // Step FSM with registered status outputs; init overrides any in-flight step.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state      <= ST_IDLE;
      step_ready <= 1'b1;
      step_dir   <= 2'b00;
      nxt_x      <= '0;
      nxt_y      <= '0;
      eat_pend   <= 1'b0;
      wall_pend  <= 1'b0;
      idx        <= '0;
      head_x     <= X_BITS'(START_X);
      head_y     <= Y_BITS'(START_Y);
      length     <= LEN_ONE;
      cur_dir    <= 2'b00;
      done       <= 1'b0;
      ate        <= 1'b0;
      wall_hit   <= 1'b0;
      self_hit   <= 1'b0;
      won        <= 1'b0;
    end else if (init) begin
      state      <= ST_IDLE;
      step_ready <= 1'b1;
      step_dir   <= 2'b00;
      eat_pend   <= 1'b0;
      wall_pend  <= 1'b0;
      idx        <= '0;
      head_x     <= X_BITS'(START_X);
      head_y     <= Y_BITS'(START_Y);
      length     <= LEN_ONE;
      cur_dir    <= 2'b00;
      done       <= 1'b0;
      ate        <= 1'b0;
      wall_hit   <= 1'b0;
      self_hit   <= 1'b0;
      won        <= 1'b0;
    end else begin
      done <= 1'b0;
      ate  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (step_valid) begin
            step_dir   <= eff_dir;
            step_ready <= 1'b0;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          nxt_x     <= nx_ext[X_BITS-1:0];
          nxt_y     <= ny_ext[Y_BITS-1:0];
          wall_pend <= wall_now;
          eat_pend  <= (nx_ext[X_BITS-1:0] == apple_x) && (ny_ext[Y_BITS-1:0] == apple_y);
          idx       <= '0;
          state     <= ST_SCAN;
        end
        ST_SCAN: begin
          if (wall_pend) begin
            wall_hit <= 1'b1;
            done     <= 1'b1;
            state    <= ST_HALT;
          end else if (self_match) begin
            self_hit <= 1'b1;
            done     <= 1'b1;
            state    <= ST_HALT;
          end else if (scan_tail) begin
            state <= ST_COMMIT;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        ST_COMMIT: begin
          head_x  <= nxt_x;
          head_y  <= nxt_y;
          cur_dir <= step_dir;
          done    <= 1'b1;
          ate     <= eat_pend;
          if (eat_pend) begin
            length <= length + LEN_ONE;
          end
          if (eat_pend && (length == LEN_PRE_WIN)) begin
            won   <= 1'b1;
            state <= ST_HALT;
          end else begin
            step_ready <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          step_ready <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sga_snake_engine.sv
// Directed self-checking bench for sga_snake_engine (4x4 grid, MAX_LEN 16).
// Expectations for the wall scenario follow SGA_WRAP_EN when it is defined.
module tb_sga_snake_engine;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] D = 2'b01;
  localparam logic [1:0] U = 2'b10;
  localparam logic [1:0] L = 2'b11;

  logic       clock = 1'b0;
  logic       restart = 1'b1;
  logic       init = 1'b0;
  logic       step_valid = 1'b0;
  logic       step_ready;
  logic [1:0] dir_in = 2'b00;
  logic [1:0] apple_x = 2'd3;
  logic [1:0] apple_y = 2'd3;
  logic [3:0] rd_idx = 4'd0;
  logic [1:0] rd_x, rd_y, head_x, head_y, cur_dir;
  logic [4:0] length;
  logic       done, ate, wall_hit, self_hit, won;

  int n_vec = 0;
  int n_err = 0;

  sga_snake_engine dut (
    .clock     (clock),
    .restart   (restart),
    .init      (init),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .dir_in    (dir_in),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .rd_idx    (rd_idx),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .cur_dir   (cur_dir),
    .done      (done),
    .ate       (ate),
    .wall_hit  (wall_hit),
    .self_hit  (self_hit),
    .won       (won)
  );

  always #5 clock = ~clock;

  task automatic do_init();
    @(negedge clock);
    init = 1'b1;
    @(negedge clock);
    init = 1'b0;
  endtask

  // Request one move; lat = cycles from the handshake edge to done, -1 if none within budget.
  task automatic do_step(input logic [1:0] d, input logic [1:0] ax, input logic [1:0] ay,
                         output int lat, output logic ate_seen);
    @(negedge clock);
    dir_in = d;
    apple_x = ax;
    apple_y = ay;
    step_valid = 1'b1;
    @(posedge clock);
    #1 step_valid = 1'b0;
    lat = -1;
    ate_seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        ate_seen = ate;
        break;
      end
    end
  endtask

  task automatic test_reset();
    restart = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    restart = 1'b0;
    rd_idx = 4'd0;
    #1;
    n_vec++; if (step_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", step_ready); end
    n_vec++; if (length !== 5'd1) begin n_err++; $display("FAIL reset_len: got %0d want 1", length); end
    n_vec++; if ({head_x, head_y} !== 4'h0) begin n_err++; $display("FAIL reset_head: got (%0d,%0d) want (0,0)", head_x, head_y); end
    n_vec++; if ({cur_dir, done, ate, wall_hit, self_hit, won} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000000", {cur_dir, done, ate, wall_hit, self_hit, won}); end
    n_vec++; if ({rd_x, rd_y} !== 4'h0) begin n_err++; $display("FAIL reset_rd0: got (%0d,%0d) want (0,0)", rd_x, rd_y); end
  endtask

  task automatic test_basic_move();
    int lat; logic a;
    do_init();
    do_step(R, 2'd3, 2'd3, lat, a);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL move1_latency: got %0d want 3", lat); end
    n_vec++; if ({head_x, head_y, a} !== {2'd1, 2'd0, 1'b0}) begin
      n_err++; $display("FAIL move1_head: got (%0d,%0d) ate %b want (1,0) ate 0", head_x, head_y, a); end
    do_step(R, 2'd3, 2'd3, lat, a);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL move2_latency: got %0d want 3", lat); end
    n_vec++; if ({head_x, head_y, length} !== {2'd2, 2'd0, 5'd1}) begin
      n_err++; $display("FAIL move2_head: got (%0d,%0d) len %0d want (2,0) len 1", head_x, head_y, length); end
  endtask

  task automatic test_eat_reverse();
    int lat; logic a;
    do_init();
    do_step(R, 2'd1, 2'd0, lat, a);
    n_vec++; if ({a, length} !== {1'b1, 5'd2}) begin n_err++; $display("FAIL eat_grow: got ate %b len %0d want ate 1 len 2", a, length); end
    rd_idx = 4'd1;
    #1;
    n_vec++; if ({rd_x, rd_y} !== {2'd0, 2'd0}) begin n_err++; $display("FAIL eat_rd1: got (%0d,%0d) want (0,0)", rd_x, rd_y); end
    do_step(L, 2'd3, 2'd3, lat, a);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL rev_latency: got %0d want 4", lat); end
    n_vec++; if ({head_x, head_y, cur_dir} !== {2'd2, 2'd0, 2'b00}) begin
      n_err++; $display("FAIL rev_ignored: got (%0d,%0d) dir %b want (2,0) dir 00", head_x, head_y, cur_dir); end
  endtask

  task automatic test_wall();
    int lat; logic a;
    do_step(R, 2'd3, 2'd3, lat, a);
    n_vec++; if ({head_x, head_y} !== {2'd3, 2'd0}) begin n_err++; $display("FAIL edge_head: got (%0d,%0d) want (3,0)", head_x, head_y); end
    do_step(R, 2'd0, 2'd3, lat, a);
`ifdef SGA_WRAP_EN
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL wrap_latency: got %0d want 4", lat); end
    n_vec++; if ({head_x, head_y, wall_hit, step_ready} !== {2'd0, 2'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL wrap_head: got (%0d,%0d) wall %b ready %b want (0,0) 0 1", head_x, head_y, wall_hit, step_ready); end
`else
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL wall_latency: got %0d want 2", lat); end
    n_vec++; if ({wall_hit, step_ready, head_x, head_y, length} !== {1'b1, 1'b0, 2'd3, 2'd0, 5'd2}) begin
      n_err++; $display("FAIL wall_state: got wall %b ready %b (%0d,%0d) len %0d want 1 0 (3,0) 2",
                        wall_hit, step_ready, head_x, head_y, length); end
    do_step(R, 2'd3, 2'd3, lat, a);
    n_vec++; if ({lat, step_ready} !== {-1, 1'b0}) begin
      n_err++; $display("FAIL halt_ignores: got lat %0d ready %b want -1 0", lat, step_ready); end
    do_init();
    #1;
    n_vec++; if ({wall_hit, step_ready, length} !== {1'b0, 1'b1, 5'd1}) begin
      n_err++; $display("FAIL wall_init: got wall %b ready %b len %0d want 0 1 1", wall_hit, step_ready, length); end
`endif
  endtask

  task automatic test_self_hit();
    int lat; logic a;
    logic [1:0] dirs [4] = '{R, R, D, L};
    logic [1:0] ax [4]   = '{2'd1, 2'd2, 2'd2, 2'd1};
    logic [1:0] ay [4]   = '{2'd0, 2'd0, 2'd1, 2'd1};
    do_init();
    for (int i = 0; i < 4; i++) begin
      do_step(dirs[i], ax[i], ay[i], lat, a);
      n_vec++; if ({lat, a} !== {i + 3, 1'b1}) begin n_err++; $display("FAIL grow%0d: got lat %0d ate %b want %0d 1", i, lat, a, i + 3); end
    end
    rd_idx = 4'd3;
    #1;
    n_vec++; if ({length, rd_x, rd_y} !== {5'd5, 2'd1, 2'd0}) begin
      n_err++; $display("FAIL loop_body: got len %0d seg3 (%0d,%0d) want 5 (1,0)", length, rd_x, rd_y); end
    do_step(U, 2'd3, 2'd3, lat, a);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL self_latency: got %0d want 5", lat); end
    n_vec++; if ({self_hit, step_ready, head_x, head_y, length} !== {1'b1, 1'b0, 2'd1, 2'd1, 5'd5}) begin
      n_err++; $display("FAIL self_state: got hit %b ready %b (%0d,%0d) len %0d want 1 0 (1,1) 5",
                        self_hit, step_ready, head_x, head_y, length); end
  endtask

  task automatic test_tail_vacate();
    int lat; logic a;
    logic [1:0] dirs [3] = '{R, D, L};
    logic [1:0] ax [3]   = '{2'd1, 2'd1, 2'd0};
    logic [1:0] ay [3]   = '{2'd0, 2'd1, 2'd1};
    do_init();
    for (int i = 0; i < 3; i++) do_step(dirs[i], ax[i], ay[i], lat, a);
    do_step(U, 2'd3, 2'd3, lat, a);
    n_vec++; if (lat !== 6) begin n_err++; $display("FAIL tail_latency: got %0d want 6", lat); end
    rd_idx = 4'd3;
    #1;
    n_vec++; if ({self_hit, head_x, head_y, length, rd_x, rd_y} !== {1'b0, 2'd0, 2'd0, 5'd4, 2'd1, 2'd0}) begin
      n_err++; $display("FAIL tail_state: got hit %b (%0d,%0d) len %0d seg3 (%0d,%0d) want 0 (0,0) 4 (1,0)",
                        self_hit, head_x, head_y, length, rd_x, rd_y); end
  endtask

  task automatic test_win();
    int lat; logic a;
    logic [1:0] dirs [15] = '{R, R, R, D, L, L, L, D, R, R, R, D, L, L, L};
    logic [1:0] ax [15]   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [1:0] ay [15]   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    do_init();
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        n_vec++; if ({length, won} !== {5'd15, 1'b0}) begin n_err++; $display("FAIL prewin: got len %0d won %b want 15 0", length, won); end
      end
      do_step(dirs[i], ax[i], ay[i], lat, a);
      n_vec++; if (lat !== i + 3) begin n_err++; $display("FAIL win_step%0d_latency: got %0d want %0d", i, lat, i + 3); end
    end
    n_vec++; if ({length, won, step_ready, head_x, head_y} !== {5'd16, 1'b1, 1'b0, 2'd0, 2'd3}) begin
      n_err++; $display("FAIL win_state: got len %0d won %b ready %b (%0d,%0d) want 16 1 0 (0,3)",
                        length, won, step_ready, head_x, head_y); end
    do_init();
    #1;
    n_vec++; if ({length, won, self_hit, wall_hit, step_ready} !== {5'd1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL win_init: got len %0d won %b self %b wall %b ready %b want 1 0 0 0 1",
                        length, won, self_hit, wall_hit, step_ready); end
  endtask

  task automatic test_abort();
    int lat; logic a; logic seen;
    do_init();
    do_step(R, 2'd1, 2'd0, lat, a);
    // restart while the scan is running
    @(negedge clock);
    dir_in = R; apple_x = 2'd3; apple_y = 2'd3; step_valid = 1'b1;
    @(posedge clock);
    #1 step_valid = 1'b0;
    @(posedge clock);
    #1 restart = 1'b1;
    #2 restart = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin @(posedge clock); #1; seen = seen | done; end
    n_vec++; if ({seen, head_x, head_y, length, step_ready} !== {1'b0, 2'd0, 2'd0, 5'd1, 1'b1}) begin
      n_err++; $display("FAIL restart_scan: got done %b (%0d,%0d) len %0d ready %b want 0 (0,0) 1 1",
                        seen, head_x, head_y, length, step_ready); end
    // init while the scan is running
    do_step(R, 2'd1, 2'd0, lat, a);
    @(negedge clock);
    dir_in = R; apple_x = 2'd3; apple_y = 2'd3; step_valid = 1'b1;
    @(posedge clock);
    #1 step_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    init = 1'b1;
    @(negedge clock);
    init = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin @(posedge clock); #1; seen = seen | done; end
    n_vec++; if ({seen, head_x, head_y, length, step_ready} !== {1'b0, 2'd0, 2'd0, 5'd1, 1'b1}) begin
      n_err++; $display("FAIL init_scan: got done %b (%0d,%0d) len %0d ready %b want 0 (0,0) 1 1",
                        seen, head_x, head_y, length, step_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_eat_reverse();
    test_wall();
    test_self_hit();
    test_tail_vacate();
    test_win();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
